// File: rtl/cplx_rd_fifo.sv
// cplx_rd_fifo: single-clock FIFO of complex {re, img} samples.
// The writer has no backpressure. A push into a full FIFO is accepted only
// when a pop happens in the same cycle. Otherwise the sample is dropped and
// the sticky ovf flag is raised.
// The head sample is shown combinationally from registered state and forced
// to zero whenever the FIFO is empty.
module cplx_rd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         in_re,
    input  logic [WIDTH-1:0]         in_img,
    input  logic                     in_valid,
    output logic [WIDTH-1:0]         out_re,
    output logic [WIDTH-1:0]         out_img,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    // Pointer wrap relies on plain binary rollover, so DEPTH must be a power of two.
    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("cplx_rd_fifo: DEPTH must be a power of two in 2..64");
    end

    // Each entry keeps re and img packed together so they can never separate.
    logic [2*WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;

    logic          not_empty;
    logic          pop_s;
    logic          push_s;
    logic [2*WIDTH-1:0] head_s;

    assign not_empty = (level_q != '0);
    assign pop_s     = not_empty && out_ready;
    // A push into a full FIFO is allowed when a pop frees a slot in the same cycle.
    assign push_s    = in_valid && ((level_q != FULL_LVL) || pop_s);

    // Next-state decode for the pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // A write that could not be stored is lost and is remembered until reset.
        if (in_valid && !push_s) begin
            ovf_d = 1'b1;
        end
    end

    // Control state, cleared asynchronously so the outputs drop as soon as reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Sample storage is not reset. Stale entries are masked by the occupancy count.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {in_re, in_img};
        end
    end

    assign head_s    = mem_q[rd_ptr_q];
    assign out_valid = not_empty;
    assign out_re    = not_empty ? head_s[2*WIDTH-1:WIDTH] : '0;
    assign out_img   = not_empty ? head_s[WIDTH-1:0]       : '0;
    assign level     = level_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cplx_rd_fifo.sv
// Directed and scoreboard-based bench for cplx_rd_fifo (WIDTH=32, DEPTH=8).
module tb_cplx_rd_fifo;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_re;
    logic [31:0] in_img;
    logic        in_valid;
    logic [31:0] out_re;
    logic [31:0] out_img;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  level;
    logic        ovf;

    int total;
    int bad;

    cplx_rd_fifo #(.WIDTH(32), .DEPTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_re     (in_re),
        .in_img    (in_img),
        .in_valid  (in_valid),
        .out_re    (out_re),
        .out_img   (out_img),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_re     = '0;
        in_img    = '0;
        rst_n     = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_re     = '0;
        in_img    = '0;
        #2;
        rst_n = 1'b0;
        cyc();
        cyc();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        total++;
        if (level !== 4'd0) begin
            bad++;
            $display("FAIL reset_level got=%0d want=0", level);
        end
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_ovf got=%b want=0", ovf);
        end
        total++;
        if (out_re !== 32'h0 || out_img !== 32'h0) begin
            bad++;
            $display("FAIL reset_data got=%h/%h want=0/0", out_re, out_img);
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_single_push();
        in_re     = 32'h0000_0001;
        in_img    = 32'h8000_0001;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_re !== 32'h0000_0001 || out_img !== 32'h8000_0001) begin
                bad++;
                $display("FAIL single_head[%0d] got v=%b %h/%h want v=1 00000001/80000001",
                         i, out_valid, out_re, out_img);
            end
            total++;
            if (level !== 4'd1) begin
                bad++;
                $display("FAIL single_level[%0d] got=%0d want=1", i, level);
            end
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        total++;
        if (out_valid !== 1'b0 || level !== 4'd0 || out_re !== 32'h0) begin
            bad++;
            $display("FAIL single_drain got v=%b lvl=%0d re=%h want v=0 lvl=0 re=0",
                     out_valid, level, out_re);
        end
        // Pop request while empty must not change anything.
        cyc();
        total++;
        if (out_valid !== 1'b0 || level !== 4'd0) begin
            bad++;
            $display("FAIL empty_pop got v=%b lvl=%0d want v=0 lvl=0", out_valid, level);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_fill_drain();
        logic [31:0] kk;
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            kk       = 32'(k);
            in_re    = kk;
            in_img   = ~kk;
            in_valid = 1'b1;
            cyc();
            total++;
            if (level !== 4'(k + 1)) begin
                bad++;
                $display("FAIL fill_level[%0d] got=%0d want=%0d", k, level, k + 1);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            kk = 32'(k);
            total++;
            if (out_valid !== 1'b1 || out_re !== kk || out_img !== ~kk) begin
                bad++;
                $display("FAIL drain_data[%0d] got v=%b %h/%h want v=1 %h/%h",
                         k, out_valid, out_re, out_img, kk, ~kk);
            end
            cyc();
        end
        total++;
        if (out_valid !== 1'b0 || out_re !== 32'h0 || out_img !== 32'h0 || level !== 4'd0) begin
            bad++;
            $display("FAIL drain_empty got v=%b %h/%h lvl=%0d want v=0 0/0 lvl=0",
                     out_valid, out_re, out_img, level);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_re    = 32'(100 + k);
            in_img   = 32'(200 + k);
            in_valid = 1'b1;
            cyc();
        end
        total++;
        if (ovf !== 1'b0 || level !== 4'd8) begin
            bad++;
            $display("FAIL ovf_prefull got ovf=%b lvl=%0d want ovf=0 lvl=8", ovf, level);
        end
        in_re  = 32'h0000_DEAD;
        in_img = 32'h0000_BEEF;
        cyc();
        in_valid = 1'b0;
        total++;
        if (ovf !== 1'b1 || level !== 4'd8) begin
            bad++;
            $display("FAIL ovf_set got ovf=%b lvl=%0d want ovf=1 lvl=8", ovf, level);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_re !== 32'(100 + k) || out_img !== 32'(200 + k)) begin
                bad++;
                $display("FAIL ovf_drain[%0d] got v=%b %h/%h want v=1 %h/%h",
                         k, out_valid, out_re, out_img, 32'(100 + k), 32'(200 + k));
            end
            cyc();
        end
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL ovf_extra got v=%b re=%h want v=0", out_valid, out_re);
        end
        in_re    = 32'h0000_0042;
        in_img   = 32'h0000_0043;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        total++;
        if (ovf !== 1'b1 || level !== 4'd1 || out_re !== 32'h42 || out_img !== 32'h43) begin
            bad++;
            $display("FAIL ovf_sticky got ovf=%b lvl=%0d %h/%h want ovf=1 lvl=1 42/43",
                     ovf, level, out_re, out_img);
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        total++;
        if (ovf !== 1'b0 || level !== 4'd0) begin
            bad++;
            $display("FAIL b2b_reset got ovf=%b lvl=%0d want ovf=0 lvl=0", ovf, level);
        end
        for (int k = 0; k < 8; k++) begin
            in_re    = 32'(k);
            in_img   = 32'(1000 + k);
            in_valid = 1'b1;
            cyc();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_re  = 32'(8 + i);
            in_img = 32'(1008 + i);
            total++;
            if (level !== 4'd8 || ovf !== 1'b0 || out_valid !== 1'b1 ||
                out_re !== 32'(i) || out_img !== 32'(1000 + i)) begin
                bad++;
                $display("FAIL b2b[%0d] got lvl=%0d ovf=%b v=%b %h/%h want lvl=8 ovf=0 v=1 %h/%h",
                         i, level, ovf, out_valid, out_re, out_img, 32'(i), 32'(1000 + i));
            end
            cyc();
        end
        in_valid = 1'b0;
        for (int i = 20; i < 28; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_re !== 32'(i) || out_img !== 32'(1000 + i)) begin
                bad++;
                $display("FAIL b2b_tail[%0d] got v=%b %h/%h want v=1 %h/%h",
                         i, out_valid, out_re, out_img, 32'(i), 32'(1000 + i));
            end
            cyc();
        end
        total++;
        if (out_valid !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end got v=%b ovf=%b want v=0 ovf=0", out_valid, ovf);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            in_re    = 32'(300 + k);
            in_img   = 32'(400 + k);
            in_valid = 1'b1;
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        out_ready = 1'b0;
        total++;
        if (level !== 4'd5 || ovf !== 1'b1 || out_re !== 32'd303) begin
            bad++;
            $display("FAIL areset_pre got lvl=%0d ovf=%b re=%0d want lvl=5 ovf=1 re=303",
                     level, ovf, out_re);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || level !== 4'd0 || ovf !== 1'b0 ||
            out_re !== 32'h0 || out_img !== 32'h0) begin
            bad++;
            $display("FAIL areset_async got v=%b lvl=%0d ovf=%b %h/%h want all 0",
                     out_valid, level, ovf, out_re, out_img);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        in_re    = 32'h55;
        in_img   = 32'h66;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_re !== 32'h55 || out_img !== 32'h66 || level !== 4'd1) begin
            bad++;
            $display("FAIL areset_after got v=%b %h/%h lvl=%0d want v=1 55/66 lvl=1",
                     out_valid, out_re, out_img, level);
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [63:0] q[$];
        logic        m_ovf;
        logic        iv;
        logic        rdy;
        logic        pop;
        logic        push;
        logic [31:0] r;
        logic [31:0] m;
        int          nbad_local;
        nbad_local = 0;
        m_ovf = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            total++;
            if (out_valid !== (q.size() != 0) || level !== 4'(q.size()) || ovf !== m_ovf ||
                level > 4'd8) begin
                bad++;
                nbad_local++;
                $display("FAIL rand_ctrl[%0d] got v=%b lvl=%0d ovf=%b want v=%b lvl=%0d ovf=%b",
                         c, out_valid, level, ovf, q.size() != 0, q.size(), m_ovf);
            end
            if (q.size() != 0) begin
                total++;
                if ({out_re, out_img} !== q[0]) begin
                    bad++;
                    nbad_local++;
                    $display("FAIL rand_data[%0d] got %h/%h want %h", c, out_re, out_img, q[0]);
                end
            end else begin
                total++;
                if (out_re !== 32'h0 || out_img !== 32'h0) begin
                    bad++;
                    nbad_local++;
                    $display("FAIL rand_zero[%0d] got %h/%h want 0/0", c, out_re, out_img);
                end
            end
            if (nbad_local > 20) break;
            iv  = 1'($urandom_range(0, 1));
            rdy = 1'($urandom_range(0, 1));
            r   = $urandom;
            m   = $urandom;
            in_valid  = iv;
            out_ready = rdy;
            in_re     = r;
            in_img    = m;
            pop  = (q.size() != 0) && rdy;
            push = iv && ((q.size() < 8) || pop);
            if (iv && !push) m_ovf = 1'b1;
            if (pop) void'(q.pop_front());
            if (push) q.push_back({r, m});
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_push();
        test_fill_drain();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
